// File: rtl/rida_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller slice.
// Provides the register file geometry, the implicit stack pointer index,
// default tuning values for the controller and the flush FSM state type.
// No ports: this file only holds a package.
package rida_ctrl_pkg;

  // Architectural register file geometry
  localparam int NREGS  = 16;
  localparam int REG_AW = $clog2(NREGS);

  // Register that PUSH/POP read and write without naming it
  localparam int SP_REG = 14;

  // Default tuning for the hazard controller
  localparam int CNT_W_DEFAULT        = 2;
  localparam int FLUSH_CYCLES_DEFAULT = 2;
  localparam int WB_BYPASS_DEFAULT    = 1;

  // Flush sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // One-hot mask selecting a single register
  function automatic logic [NREGS-1:0] regBit(input logic [REG_AW-1:0] r);
    logic [NREGS-1:0] mask;
    mask    = '0;
    mask[r] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write scoreboard.
// Each architectural register owns a small saturating counter of writes that
// have issued but not yet written back.
// Ports:
//   clk, rst  clock and asynchronous active-low reset
//   incVec    one bit per register: a write to it issued this cycle
//   decVec    one bit per register: a write to it retired this cycle
//   nonZero   one bit per register: counter is nonzero (write outstanding)
//   isOne     one bit per register: exactly one write outstanding
//   isMax     one bit per register: counter saturated, no further issue allowed
module reg_scoreboard
  import rida_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] incVec,
  input  logic [NREGS-1:0] decVec,
  output logic [NREGS-1:0] nonZero,
  output logic [NREGS-1:0] isOne,
  output logic [NREGS-1:0] isMax
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] underflowVec;
  logic [NREGS-1:0] overflowVec;

  // Counter update. An issue and a retirement to the same register in the
  // same cycle cancel out. Retiring a register with nothing outstanding is
  // dropped rather than wrapping, and incrementing a saturated counter is
  // dropped too; the hazard logic upstream should make both impossible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        case ({incVec[i], decVec[i]})
          2'b10: if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_ONE;
          2'b01: if (cnt[i] != '0)      cnt[i] <= cnt[i] - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  // Status flags the hazard logic consumes, one bit per register
  always_comb begin
    nonZero = '0;
    isOne   = '0;
    isMax   = '0;
    for (int i = 0; i < NREGS; i++) begin
      nonZero[i] = (cnt[i] != '0);
      isOne[i]   = (cnt[i] == CNT_ONE);
      isMax[i]   = (cnt[i] == CNT_MAX);
    end
  end

  // A writeback for a register with no outstanding write, or an issue into
  // a saturated counter, means the pipeline and scoreboard disagree.
  assign underflowVec = decVec & ~incVec & ~nonZero;
  assign overflowVec  = incVec & ~decVec & isMax;

  noUnderflow: assert property (@(posedge clk) disable iff (!rst) underflowVec == '0);
  noOverflow:  assert property (@(posedge clk) disable iff (!rst) overflowVec == '0);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode->Execute hazard controller.
// Tracks in-flight register writes, stalls Fetch/Decode on read-after-write
// hazards or scoreboard saturation, and sequences Fetch/Decode flushes after
// a taken branch resolves in Execute.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   dec_*           instruction currently held in Decode (sources, dest, PUSH/POP)
//   wb_valid/wb_rd  register writeback retiring this cycle
//   branch_taken_e  taken branch resolved in Execute this cycle
//   stall_fd        hold PC and F/D register
//   flush_f         squash F/D register contents
//   flush_d         insert bubble into D/E register
//   issue_o         instruction advances D->E this cycle
//   pending_o       per-register "write outstanding" flags
//   stall_cnt_o     saturating count of stalled cycles
module decode_hazard_ctrl
  import rida_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int WB_BYPASS    = WB_BYPASS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic              dec_rs1_used,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_rs2_used,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_regwrite,
  input  logic              dec_sp_use,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              branch_taken_e,
  output logic              stall_fd,
  output logic              flush_f,
  output logic              flush_d,
  output logic              issue_o,
  output logic [NREGS-1:0]  pending_o,
  output logic [15:0]       stall_cnt_o
);

  // fcnt holds how many more FLUSH cycles follow the current one. The cycle
  // in which the branch arrives already flushes, so a window of N cycles
  // needs N-2 extra FLUSH cycles after the first FLUSH cycle.
  localparam int FCNT_W    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam int FCNT_LOAD = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);
  localparam logic [REG_AW-1:0] SP_IDX   = REG_AW'(SP_REG);

  flush_state_t      flushState;
  logic [FCNT_W-1:0] fcnt;

  logic [NREGS-1:0] incVec;
  logic [NREGS-1:0] decVec;
  logic [NREGS-1:0] nonZero;
  logic [NREGS-1:0] isOne;
  logic [NREGS-1:0] isMax;
  logic [NREGS-1:0] bypassVec;
  logic [NREGS-1:0] hazardVec;

  logic flushing;
  logic rawHazard;
  logic sbFull;
  logic stallInt;
  logic issueInt;

  reg_scoreboard #(
    .CNT_W (CNT_W)
  ) uScoreboard (
    .clk     (clk),
    .rst     (rst),
    .incVec  (incVec),
    .decVec  (decVec),
    .nonZero (nonZero),
    .isOne   (isOne),
    .isMax   (isMax)
  );

  assign pending_o = nonZero;

  // A register whose only outstanding write is retiring right now is safe
  // to read when the register file forwards same-cycle writes.
  always_comb begin
    decVec    = wb_valid ? regBit(wb_rd) : '0;
    bypassVec = (WB_BYPASS != 0) ? (decVec & isOne) : '0;
    hazardVec = nonZero & ~bypassVec;
  end

  // Stall causes: a source still waiting on a write, or a destination whose
  // counter has no room left. PUSH/POP touch the stack pointer implicitly.
  always_comb begin
    rawHazard = dec_valid & ((dec_rs1_used & hazardVec[dec_rs1])
                           | (dec_rs2_used & hazardVec[dec_rs2])
                           | (dec_sp_use   & hazardVec[SP_IDX]));
    sbFull    = dec_valid & ((dec_regwrite & isMax[dec_rd])
                           | (dec_sp_use   & isMax[SP_IDX]));
  end

  // A taken branch flushes in the very cycle it resolves, and it overrides
  // any stall because the instruction in Decode is being squashed anyway.
  // Every control output is held low while reset is asserted.
  always_comb begin
    flushing = (flushState == FLUSH) | branch_taken_e;
    stallInt = (rawHazard | sbFull) & ~flushing;
    issueInt = dec_valid & ~stallInt & ~flushing;
    stall_fd = rst & stallInt;
    flush_f  = rst & flushing;
    flush_d  = rst & (stallInt | flushing);
    issue_o  = rst & issueInt;
  end

  // Issue marks the destination busy; a PUSH/POP that also names SP as its
  // destination still counts as a single write to SP.
  always_comb begin
    incVec = '0;
    if (issue_o && dec_regwrite) incVec = incVec | regBit(dec_rd);
    if (issue_o && dec_sp_use)   incVec = incVec | regBit(SP_IDX);
  end

  // Flush sequencer. A branch arriving mid-flush restarts the window. When
  // the window is a single cycle the branch cycle covers it entirely and
  // the FSM never leaves IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushState <= IDLE;
      fcnt       <= '0;
    end else if (branch_taken_e) begin
      fcnt <= FCNT_W'(FCNT_LOAD);
      if (FLUSH_CYCLES >= 2) flushState <= FLUSH;
      else                   flushState <= IDLE;
    end else if (flushState == FLUSH) begin
      if (fcnt == '0) flushState <= IDLE;
      else            fcnt       <= fcnt - FCNT_ONE;
    end
  end

  // Performance counter of stalled cycles, pinned at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (stall_fd && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl.
// Directed vectors with hand-computed expectations are pushed into a queue
// as each vector is driven; a separate monitor pops and compares every cycle.
module tb_decode_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [3:0]  dec_rs1;
  logic        dec_rs1_used;
  logic [3:0]  dec_rs2;
  logic        dec_rs2_used;
  logic [3:0]  dec_rd;
  logic        dec_regwrite;
  logic        dec_sp_use;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        branch_taken_e;
  logic        stall_fd;
  logic        flush_f;
  logic        flush_d;
  logic        issue_o;
  logic [15:0] pending_o;
  logic [15:0] stall_cnt_o;

  typedef struct packed {
    logic       rstN;
    logic       valid;
    logic [3:0] rs1;
    logic       rs1u;
    logic [3:0] rs2;
    logic       rs2u;
    logic [3:0] rd;
    logic       rw;
    logic       sp;
    logic       wbv;
    logic [3:0] wbrd;
    logic       br;
  } stim_t;

  typedef struct {
    string       name;
    logic [35:0] exp;
  } expEntry_t;

  expEntry_t expQ[$];
  int        passCount = 0;
  int        totalCount = 0;
  int        tbStallCnt = 0;

  decode_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid      (dec_valid),
    .dec_rs1        (dec_rs1),
    .dec_rs1_used   (dec_rs1_used),
    .dec_rs2        (dec_rs2),
    .dec_rs2_used   (dec_rs2_used),
    .dec_rd         (dec_rd),
    .dec_regwrite   (dec_regwrite),
    .dec_sp_use     (dec_sp_use),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .branch_taken_e (branch_taken_e),
    .stall_fd       (stall_fd),
    .flush_f        (flush_f),
    .flush_d        (flush_d),
    .issue_o        (issue_o),
    .pending_o      (pending_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkIn(input logic rstN, input logic valid,
                                 input logic [3:0] rs1, input logic rs1u,
                                 input logic [3:0] rs2, input logic rs2u,
                                 input logic [3:0] rd, input logic rw,
                                 input logic sp, input logic wbv,
                                 input logic [3:0] wbrd, input logic br);
    stim_t s;
    s.rstN = rstN; s.valid = valid; s.rs1 = rs1; s.rs1u = rs1u;
    s.rs2 = rs2; s.rs2u = rs2u; s.rd = rd; s.rw = rw; s.sp = sp;
    s.wbv = wbv; s.wbrd = wbrd; s.br = br;
    return s;
  endfunction

  // Drive one cycle of inputs shortly after the rising edge and queue the
  // outputs expected during that cycle. The expected stall counter is the
  // number of stall cycles expected so far since the last reset.
  task automatic applyStimulus(input string name, input stim_t s,
                               input logic stall, input logic flushF,
                               input logic flushD, input logic issue,
                               input logic [15:0] pend);
    expEntry_t e;
    @(posedge clk);
    #1;
    rst            = s.rstN;
    dec_valid      = s.valid;
    dec_rs1        = s.rs1;
    dec_rs1_used   = s.rs1u;
    dec_rs2        = s.rs2;
    dec_rs2_used   = s.rs2u;
    dec_rd         = s.rd;
    dec_regwrite   = s.rw;
    dec_sp_use     = s.sp;
    wb_valid       = s.wbv;
    wb_rd          = s.wbrd;
    branch_taken_e = s.br;
    if (!s.rstN) tbStallCnt = 0;
    e.name = name;
    e.exp  = {stall, flushF, flushD, issue, pend, 16'(tbStallCnt)};
    expQ.push_back(e);
    if (stall) tbStallCnt++;
  endtask

  task automatic checkOutput(input expEntry_t e);
    logic [35:0] act;
    act = {stall_fd, flush_f, flush_d, issue_o, pending_o, stall_cnt_o};
    totalCount++;
    if (act === e.exp) passCount++;
    else $display("[TB] FAIL %s: got {stall,flf,fld,iss,pend,scnt}=%h expected %h",
                  e.name, act, e.exp);
  endtask

  // Monitor: compare on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0;
    dec_rs2_used = 0; dec_rd = 0; dec_regwrite = 0; dec_sp_use = 0;
    wb_valid = 0; wb_rd = 0; branch_taken_e = 0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 4; i++) begin
      s = 24'($urandom);
      s.rstN = 1'b0;
      applyStimulus("reset_hold", s, 0, 0, 0, 0, 16'h0000);
    end
    applyStimulus("rst_release", mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0000);

    $display("[TB] read-after-write");
    applyStimulus("raw_issue_r3",  mkIn(1,1,0,0,0,0,3,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("raw_stall_a",   mkIn(1,1,3,1,0,0,4,1,0,0,0,0), 1,0,1,0, 16'h0008);
    applyStimulus("raw_stall_b",   mkIn(1,1,3,1,0,0,4,1,0,0,0,0), 1,0,1,0, 16'h0008);
    applyStimulus("raw_wb_bypass", mkIn(1,1,3,1,0,0,4,1,0,1,3,0), 0,0,0,1, 16'h0008);
    applyStimulus("raw_after_wb",  mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0010);
    applyStimulus("raw_drain_r4",  mkIn(1,0,0,0,0,0,0,0,0,1,4,0), 0,0,0,0, 16'h0010);
    applyStimulus("rs2_issue_r7",  mkIn(1,1,0,0,0,0,7,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("rs2_stall",     mkIn(1,1,0,0,7,1,0,0,0,0,0,0), 1,0,1,0, 16'h0080);
    applyStimulus("rs_unused",     mkIn(1,1,7,0,7,0,0,0,0,0,0,0), 0,0,0,1, 16'h0080);
    applyStimulus("rs2_drain_r7",  mkIn(1,0,0,0,0,0,0,0,0,1,7,0), 0,0,0,0, 16'h0080);

    $display("[TB] scoreboard saturation");
    applyStimulus("sat_w1",        mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("sat_w2",        mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 0,0,0,1, 16'h0020);
    applyStimulus("sat_w3",        mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 0,0,0,1, 16'h0020);
    applyStimulus("sat_w4_stall",  mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 1,0,1,0, 16'h0020);
    applyStimulus("sat_full_wb",   mkIn(1,1,0,0,0,0,5,1,0,1,5,0), 1,0,1,0, 16'h0020);
    applyStimulus("sat_inc_dec",   mkIn(1,1,0,0,0,0,5,1,0,1,5,0), 0,0,0,1, 16'h0020);
    applyStimulus("sat_refill",    mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 0,0,0,1, 16'h0020);
    applyStimulus("sat_full_chk",  mkIn(1,1,0,0,0,0,5,1,0,0,0,0), 1,0,1,0, 16'h0020);
    applyStimulus("sat_drain_a",   mkIn(1,0,0,0,0,0,0,0,0,1,5,0), 0,0,0,0, 16'h0020);
    applyStimulus("sat_drain_b",   mkIn(1,0,0,0,0,0,0,0,0,1,5,0), 0,0,0,0, 16'h0020);
    applyStimulus("sat_drain_c",   mkIn(1,0,0,0,0,0,0,0,0,1,5,0), 0,0,0,0, 16'h0020);
    applyStimulus("sat_empty",     mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0000);

    $display("[TB] branch flush");
    applyStimulus("br_cycle0",     mkIn(1,1,0,0,0,0,1,1,0,0,0,1), 0,1,1,0, 16'h0000);
    applyStimulus("br_cycle1",     mkIn(1,1,0,0,0,0,1,1,0,0,0,0), 0,1,1,0, 16'h0000);
    applyStimulus("br_done",       mkIn(1,1,0,0,0,0,1,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("br_drain_r1",   mkIn(1,0,0,0,0,0,0,0,0,1,1,0), 0,0,0,0, 16'h0002);
    applyStimulus("brx_issue_r6",  mkIn(1,1,0,0,0,0,6,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("brx_over_stall",mkIn(1,1,6,1,0,0,0,0,0,0,0,1), 0,1,1,0, 16'h0040);
    applyStimulus("brx_reload",    mkIn(1,1,6,1,0,0,0,0,0,0,0,1), 0,1,1,0, 16'h0040);
    applyStimulus("brx_tail",      mkIn(1,1,6,1,0,0,0,0,0,0,0,0), 0,1,1,0, 16'h0040);
    applyStimulus("brx_stall",     mkIn(1,1,6,1,0,0,0,0,0,0,0,0), 1,0,1,0, 16'h0040);
    applyStimulus("brx_wb_bypass", mkIn(1,1,6,1,0,0,0,0,0,1,6,0), 0,0,0,1, 16'h0040);
    applyStimulus("brx_empty",     mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0000);

    $display("[TB] push/pop");
    applyStimulus("push",          mkIn(1,1,0,0,0,0,0,0,1,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("pop_stall_a",   mkIn(1,1,0,0,0,0,2,1,1,0,0,0), 1,0,1,0, 16'h4000);
    applyStimulus("pop_stall_b",   mkIn(1,1,0,0,0,0,2,1,1,0,0,0), 1,0,1,0, 16'h4000);
    applyStimulus("pop_wb_sp",     mkIn(1,1,0,0,0,0,2,1,1,1,14,0), 0,0,0,1, 16'h4000);
    applyStimulus("pop_drain_sp",  mkIn(1,0,0,0,0,0,0,0,0,1,14,0), 0,0,0,0, 16'h4004);
    applyStimulus("pop_drain_r2",  mkIn(1,0,0,0,0,0,0,0,0,1,2,0), 0,0,0,0, 16'h0004);
    applyStimulus("push_rd_sp",    mkIn(1,1,0,0,0,0,14,1,1,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("push_sp_wb",    mkIn(1,0,0,0,0,0,0,0,0,1,14,0), 0,0,0,0, 16'h4000);
    applyStimulus("push_sp_once",  mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0000);

    $display("[TB] async reset mid-flush");
    applyStimulus("ar_issue_a",    mkIn(1,1,0,0,0,0,3,1,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("ar_issue_b",    mkIn(1,1,0,0,0,0,3,1,0,0,0,0), 0,0,0,1, 16'h0008);
    applyStimulus("ar_branch",     mkIn(1,1,0,0,0,0,3,1,0,0,0,1), 0,1,1,0, 16'h0008);
    applyStimulus("ar_reset",      mkIn(0,1,0,0,0,0,3,1,0,0,0,1), 0,0,0,0, 16'h0000);
    applyStimulus("ar_after",      mkIn(1,1,3,1,0,0,0,0,0,0,0,0), 0,0,0,1, 16'h0000);
    applyStimulus("ar_idle",       mkIn(1,0,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 16'h0000);

    // Let the monitor drain the queue, bounded by a few cycles
    repeat (2) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      totalCount++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
